hazard_tracker: RTL and testbench

HAZARD_TRACKER -- requirements
Module: hazard_tracker

---
 rtl/hazard_pkg.sv | 27 ++
 rtl/fwd_select.sv | 29 ++
 rtl/hazard_tracker.sv | 158 +++++++++++++++
 tb/tb_hazard_tracker.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and the per-stage instruction tag for the hazard tracker.
package hazard_pkg;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic       valid;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic       uses_rs1;
    logic       uses_rs2;
    logic [3:0] rd;
    logic       regwrite;
    logic       memread;
    logic       memwrite;
  } stage_tag_t;

  localparam stage_tag_t BUBBLE_TAG = '0;

endpackage

// File: rtl/fwd_select.sv
// Operand forward-source selection for one EX operand; MEM result wins over WB.
module fwd_select
  import hazard_pkg::*;
(
  input  logic       uses_rs,
  input  logic [3:0] rs,
  input  logic       mem_valid,
  input  logic       mem_regwrite,
  input  logic       mem_memread,
  input  logic [3:0] mem_rd,
  input  logic       wb_valid,
  input  logic       wb_regwrite,
  input  logic [3:0] wb_rd,
  output logic [1:0] sel
);

  // A load in MEM has no data yet, so it never forwards from that stage.
  always_comb begin
    sel = FWD_RF;
    if (uses_rs && (rs != 4'd0)) begin
      if (mem_valid && mem_regwrite && !mem_memread && (mem_rd == rs)) begin
        sel = FWD_MEM;
      end else if (wb_valid && wb_regwrite && (wb_rd == rs)) begin
        sel = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Pipeline hazard tracker: load-use stall, memory-wait freeze, flush and forwarding.
// Optional memory-wait timeout enabled by defining HAZARD_MEM_TIMEOUT_EN.
module hazard_tracker
  import hazard_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       id_valid,
  input  logic [3:0] id_rs1,
  input  logic [3:0] id_rs2,
  input  logic       id_uses_rs1,
  input  logic       id_uses_rs2,
  input  logic [3:0] id_rd,
  input  logic       id_regwrite,
  input  logic       id_memread,
  input  logic       id_memwrite,
  input  logic       mem_ready,
  input  logic       flush,
  output logic       stall,
  output logic       bubble,
  output logic       freeze,
  output logic [1:0] fwd_sel0,
  output logic [1:0] fwd_sel1,
  output logic [3:0] mem_rd,
  output logic [3:0] wb_rd,
  output logic       wb_we,
  output logic       state,
  output logic       mem_timeout
);

  stage_tag_t ex_q, ex_d, mem_q, mem_d, wb_q, wb_d, id_tag;
  logic       pend_flush_q, pend_flush_d;
  logic       wait_cond, load_use, flush_eff, timeout_hit;
  hz_state_e  state_cur;
  logic       unused_wb_bits;

  always_comb begin
    id_tag.valid    = id_valid;
    id_tag.rs1      = id_rs1;
    id_tag.rs2      = id_rs2;
    id_tag.uses_rs1 = id_uses_rs1;
    id_tag.uses_rs2 = id_uses_rs2;
    id_tag.rd       = id_rd;
    id_tag.regwrite = id_regwrite;
    id_tag.memread  = id_memread;
    id_tag.memwrite = id_memwrite;
  end

  always_comb begin
    wait_cond = mem_q.valid && (mem_q.memread || mem_q.memwrite) && !mem_ready;
    load_use  = ex_q.valid && ex_q.memread && ex_q.regwrite && (ex_q.rd != 4'd0) && id_valid &&
                ((id_uses_rs1 && (id_rs1 == ex_q.rd)) || (id_uses_rs2 && (id_rs2 == ex_q.rd)));
    flush_eff = flush || pend_flush_q;
    state_cur = wait_cond ? ST_WAIT : ST_RUN;
  end

  // A flush replaces the load-use stall: the dependent instruction is discarded anyway.
  assign freeze = wait_cond;
  assign stall  = wait_cond || (load_use && !flush_eff);
  assign bubble = reset_n && !wait_cond && (load_use || flush_eff);
  assign state  = state_cur;
  assign mem_rd = mem_q.rd;
  assign wb_rd  = wb_q.rd;
  assign wb_we  = wb_q.valid && wb_q.regwrite && (wb_q.rd != 4'd0);

  assign unused_wb_bits = ^{wb_q.rs1, wb_q.rs2, wb_q.uses_rs1, wb_q.uses_rs2,
                            wb_q.memread, wb_q.memwrite};

  always_comb begin
    ex_d         = ex_q;
    mem_d        = mem_q;
    wb_d         = wb_q;
    pend_flush_d = pend_flush_q;
    if (wait_cond) begin
      // Clearing WB.valid keeps the held WB tag from writing back a second time.
      wb_d.valid = 1'b0;
      if (flush) pend_flush_d = 1'b1;
      if (timeout_hit) mem_d = BUBBLE_TAG;
    end else begin
      wb_d         = mem_q;
      mem_d        = ex_q;
      pend_flush_d = 1'b0;
      if (flush_eff || load_use || !id_valid) begin
        ex_d = BUBBLE_TAG;
      end else begin
        ex_d = id_tag;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_q         <= BUBBLE_TAG;
      mem_q        <= BUBBLE_TAG;
      wb_q         <= BUBBLE_TAG;
      pend_flush_q <= 1'b0;
    end else begin
      ex_q         <= ex_d;
      mem_q        <= mem_d;
      wb_q         <= wb_d;
      pend_flush_q <= pend_flush_d;
    end
  end

`ifdef HAZARD_MEM_TIMEOUT_EN
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic       mem_timeout_q, mem_timeout_d;

  // The 255th consecutive wait cycle gives up on the access and drops it from MEM.
  always_comb begin
    timeout_hit   = wait_cond && (wait_cnt_q == 8'd254);
    wait_cnt_d    = (wait_cond && !timeout_hit) ? (wait_cnt_q + 8'd1) : 8'd0;
    mem_timeout_d = mem_timeout_q || timeout_hit;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q    <= 8'd0;
      mem_timeout_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign mem_timeout = mem_timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign mem_timeout = 1'b0;
`endif

  fwd_select u_fwd_a (
    .uses_rs      (ex_q.uses_rs1),
    .rs           (ex_q.rs1),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_memread  (mem_q.memread),
    .mem_rd       (mem_q.rd),
    .wb_valid     (wb_q.valid),
    .wb_regwrite  (wb_q.regwrite),
    .wb_rd        (wb_q.rd),
    .sel          (fwd_sel0)
  );

  fwd_select u_fwd_b (
    .uses_rs      (ex_q.uses_rs2),
    .rs           (ex_q.rs2),
    .mem_valid    (mem_q.valid),
    .mem_regwrite (mem_q.regwrite),
    .mem_memread  (mem_q.memread),
    .mem_rd       (mem_q.rd),
    .wb_valid     (wb_q.valid),
    .wb_regwrite  (wb_q.regwrite),
    .wb_rd        (wb_q.rd),
    .sel          (fwd_sel1)
  );

endmodule

// File: tb/tb_hazard_tracker.sv
// Directed self-checking bench for hazard_tracker; timeout section follows HAZARD_MEM_TIMEOUT_EN.
module tb_hazard_tracker;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_regwrite, id_memread, id_memwrite;
  logic [3:0] id_rs1, id_rs2, id_rd;
  logic       mem_ready, flush;
  logic       stall, bubble, freeze, wb_we, state, mem_timeout;
  logic [1:0] fwd_sel0, fwd_sel1;
  logic [3:0] mem_rd, wb_rd;

  int checks = 0;
  int failures = 0;

  hazard_tracker dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_memwrite (id_memwrite),
    .mem_ready   (mem_ready),
    .flush       (flush),
    .stall       (stall),
    .bubble      (bubble),
    .freeze      (freeze),
    .fwd_sel0    (fwd_sel0),
    .fwd_sel1    (fwd_sel1),
    .mem_rd      (mem_rd),
    .wb_rd       (wb_rd),
    .wb_we       (wb_we),
    .state       (state),
    .mem_timeout (mem_timeout)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [3:0] rs1, input logic [3:0] rs2,
                               input logic u1, input logic u2, input logic [3:0] rd,
                               input logic rw, input logic mr, input logic mw);
    id_valid    = v;
    id_rs1      = rs1;
    id_rs2      = rs2;
    id_uses_rs1 = u1;
    id_uses_rs2 = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_memwrite = mw;
    #1;
  endtask

  task automatic nop();
    applyStimulus(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [3:0] rd, input logic [3:0] a, input logic [3:0] b);
    applyStimulus(1'b1, a, b, 1'b1, 1'b1, rd, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic load(input logic [3:0] rd, input logic [3:0] a);
    applyStimulus(1'b1, a, 4'd0, 1'b1, 1'b0, rd, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic store(input logic [3:0] rd, input logic [3:0] a, input logic [3:0] b);
    applyStimulus(1'b1, a, b, 1'b1, 1'b1, rd, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    mem_ready = 1'b1;
    flush     = 1'b1;
    nop();
    checkOutput("rst_stall", stall, 0);
    checkOutput("rst_bubble", bubble, 0);
    checkOutput("rst_freeze", freeze, 0);
    checkOutput("rst_fwd0", fwd_sel0, 0);
    checkOutput("rst_fwd1", fwd_sel1, 0);
    checkOutput("rst_rds", {mem_rd, wb_rd}, 0);
    checkOutput("rst_wbwe", wb_we, 0);
    checkOutput("rst_state", state, 0);
    checkOutput("rst_timeout", mem_timeout, 0);
    tick();
    tick();
    flush   = 1'b0;
    reset_n = 1'b1;

    // Load r3 followed by a dependent add.
    load(4'd3, 4'd1);
    checkOutput("lu_pre_stall", stall, 0);
    tick();
    alu(4'd4, 4'd3, 4'd1);
    checkOutput("lu_stall", stall, 1);
    checkOutput("lu_bubble", bubble, 1);
    tick();
    checkOutput("lu_stall_once", stall, 0);
    checkOutput("lu_bubble_once", bubble, 0);
    checkOutput("lu_mem_rd", mem_rd, 3);
    tick();
    nop();
    checkOutput("lu_fwd0_wb", fwd_sel0, 2);
    checkOutput("lu_fwd1_rf", fwd_sel1, 0);
    checkOutput("lu_wb_we", wb_we, 1);
    checkOutput("lu_wb_rd", wb_rd, 3);
    tick();

    // ALU-to-ALU forwarding from MEM on both operands.
    alu(4'd5, 4'd1, 4'd2);
    tick();
    alu(4'd6, 4'd5, 4'd5);
    checkOutput("alu_no_stall", stall, 0);
    tick();
    nop();
    checkOutput("alu_fwd0_mem", fwd_sel0, 1);
    checkOutput("alu_fwd1_mem", fwd_sel1, 1);
    tick();

    // Two writes to r8 back to back: the younger one in MEM must win.
    alu(4'd8, 4'd1, 4'd2);
    tick();
    alu(4'd8, 4'd2, 4'd1);
    tick();
    alu(4'd10, 4'd8, 4'd8);
    tick();
    nop();
    checkOutput("prio_fwd0", fwd_sel0, 1);
    checkOutput("prio_fwd1", fwd_sel1, 1);
    tick();

    // Register 0 is never a hazard or a forward source.
    load(4'd0, 4'd1);
    tick();
    alu(4'd0, 4'd0, 4'd0);
    checkOutput("r0_no_stall", stall, 0);
    checkOutput("r0_no_bubble", bubble, 0);
    tick();
    alu(4'd12, 4'd0, 4'd0);
    tick();
    nop();
    checkOutput("r0_fwd0", fwd_sel0, 0);
    checkOutput("r0_fwd1", fwd_sel1, 0);
    checkOutput("r0_wbwe_load", wb_we, 0);
    tick();
    nop();
    checkOutput("r0_wbwe_alu", wb_we, 0);
    tick();

    // Store stalls in MEM for three cycles.
    alu(4'd15, 4'd1, 4'd2);
    tick();
    store(4'd9, 4'd1, 4'd2);
    tick();
    alu(4'd13, 4'd15, 4'd1);
    tick();
    mem_ready = 1'b0;
    alu(4'd14, 4'd1, 4'd2);
    checkOutput("w1_freeze", freeze, 1);
    checkOutput("w1_stall", stall, 1);
    checkOutput("w1_state", state, 1);
    checkOutput("w1_bubble", bubble, 0);
    checkOutput("w1_wb_we", wb_we, 1);
    checkOutput("w1_fwd0", fwd_sel0, 2);
    tick();
    checkOutput("w2_freeze", freeze, 1);
    checkOutput("w2_state", state, 1);
    checkOutput("w2_wb_we", wb_we, 0);
    checkOutput("w2_wb_rd", wb_rd, 15);
    checkOutput("w2_mem_rd", mem_rd, 9);
    tick();
    checkOutput("w3_freeze", freeze, 1);
    checkOutput("w3_mem_rd", mem_rd, 9);
    tick();
    mem_ready = 1'b1;
    #1;
    checkOutput("w4_freeze", freeze, 0);
    checkOutput("w4_state", state, 0);
    checkOutput("w4_stall", stall, 0);
    tick();
    nop();
    checkOutput("w5_mem_rd", mem_rd, 13);
    checkOutput("w5_wb_rd", wb_rd, 9);
    checkOutput("w5_wb_we", wb_we, 0);

    // Flush pulsed while frozen is applied once the freeze lifts.
    load(4'd10, 4'd1);
    tick();
    nop();
    tick();
    mem_ready = 1'b0;
    flush     = 1'b1;
    load(4'd7, 4'd2);
    checkOutput("pf_freeze", freeze, 1);
    checkOutput("pf_bubble_frozen", bubble, 0);
    tick();
    flush = 1'b0;
    #1;
    checkOutput("pf_freeze2", freeze, 1);
    tick();
    mem_ready = 1'b1;
    #1;
    checkOutput("pf_apply_bubble", bubble, 1);
    checkOutput("pf_apply_stall", stall, 0);
    tick();
    load(4'd7, 4'd2);
    checkOutput("pf_cleared_bubble", bubble, 0);
    checkOutput("pf_ex_was_bubble", stall, 0);
    checkOutput("pf_wb_rd", wb_rd, 10);
    tick();
    applyStimulus(1'b1, 4'd7, 4'd0, 1'b1, 1'b0, 4'd11, 1'b1, 1'b0, 1'b0);
    checkOutput("lu2_stall", stall, 1);
    checkOutput("lu2_bubble", bubble, 1);
    flush = 1'b1;
    #1;
    checkOutput("fl_over_stall", stall, 0);
    checkOutput("fl_over_bubble", bubble, 1);
    flush = 1'b0;
    #1;
    tick();
    checkOutput("lu2_mem_rd", mem_rd, 7);
    tick();
    nop();
    checkOutput("lu2_fwd0", fwd_sel0, 2);
    tick();

    // Long memory wait, then reset while the access may still be pending.
    store(4'd9, 4'd1, 4'd2);
    tick();
    nop();
    tick();
    mem_ready = 1'b0;
    #1;
    for (int i = 1; i <= 300; i++) begin
      if (i == 1) checkOutput("lw_state_1", state, 1);
`ifdef HAZARD_MEM_TIMEOUT_EN
      if (i == 255) begin
        checkOutput("lw_state_255", state, 1);
        checkOutput("lw_to_255", mem_timeout, 0);
      end
      if (i == 256) begin
        checkOutput("lw_state_256", state, 0);
        checkOutput("lw_to_256", mem_timeout, 1);
      end
      if (i == 300) checkOutput("lw_to_300", mem_timeout, 1);
`else
      if (i == 256) checkOutput("lw_state_256", state, 1);
      if (i == 300) begin
        checkOutput("lw_state_300", state, 1);
        checkOutput("lw_to_300", mem_timeout, 0);
      end
`endif
      tick();
    end
    reset_n = 1'b0;
    #1;
    checkOutput("mr_state", state, 0);
    checkOutput("mr_freeze", freeze, 0);
    checkOutput("mr_mem_rd", mem_rd, 0);
    checkOutput("mr_timeout", mem_timeout, 0);
    mem_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    #1;
    checkOutput("mr_rel_wb_we", wb_we, 0);
    tick();
    checkOutput("mr_rel_wb_we2", wb_we, 0);
    checkOutput("mr_rel_state", state, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
